// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes from ALU_Control
// and the execute-stage FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_JR  = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/alu_exec_seq_if.sv
// Issue/completion bundle for the execute-stage ALU.
// master: issuer (start, alu_ctrl, op_a, op_b, shamt out;
//   busy, done, result, zero, illegal in). slave: the ALU.
interface alu_exec_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output start, alu_ctrl, op_a, op_b, shamt,
    input  busy, done, result, zero, illegal
  );

  modport slave (
    input  start, alu_ctrl, op_a, op_b, shamt,
    output busy, done, result, zero, illegal
  );
endinterface

// File: rtl/alu_comb_core.sv
// Combinational single-cycle ALU function f(alu_ctrl, A, B).
// Ports: alu_ctrl, a, b in; res, illegal out.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             illegal
);

  logic lt;
  assign lt = $signed(a) < $signed(b);

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (alu_ctrl)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_SLT: res = {{(WIDTH-1){1'b0}}, lt};
      ALU_JR:  res = a;
      // sll by zero is a plain pass of B
      ALU_SLL: res = b;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_seq.sv
// Execute-stage ALU: registered single-cycle ops, iterative sll.
// Ports: clk, reset (async, active-high), bus (slave modport).
module alu_exec_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic         clk,
  input  logic         reset,
  alu_exec_seq_if.slave bus
);

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] core_res;
  logic             core_ill;
  logic [WIDTH-1:0] acc_shl;
  logic             do_shift;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .alu_ctrl (bus.alu_ctrl),
    .a        (bus.op_a),
    .b        (bus.op_b),
    .res      (core_res),
    .illegal  (core_ill)
  );

  assign acc_shl  = acc_q << 1;
  assign do_shift = (bus.alu_ctrl == ALU_SLL)
                  && (bus.shamt != '0);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (do_shift) begin
            acc_d   = bus.op_b;
            cnt_d   = bus.shamt;
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            result_d  = core_res;
            zero_d    = (core_res == '0);
            illegal_d = core_ill;
            done_d    = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = acc_shl;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d  = acc_shl;
          zero_d    = (acc_shl == '0);
          illegal_d = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq.
// Drives on negedge, samples 1ns after posedge.
module tb_alu_exec_seq;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_exec_seq_if #(.WIDTH(32), .SHW(5)) bus ();

  alu_exec_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st,
                       input logic [3:0] c,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] sh);
    bus.start    = st;
    bus.alu_ctrl = c;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.shamt    = sh;
  endtask

  // Present an op at negedge, consume one edge, drop start.
  task automatic issue(input logic [3:0] c,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] sh);
    @(negedge clk);
    drive(1'b1, c, a, b, sh);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic d,
                         input logic [31:0] r,
                         input logic z,
                         input logic il);
    check({tag, "_done"}, 32'(bus.done), 32'(d));
    check({tag, "_res"}, bus.result, r);
    check({tag, "_zero"}, 32'(bus.zero), 32'(z));
    check({tag, "_ill"}, 32'(bus.illegal), 32'(il));
  endtask

  initial begin
    int n;
    int busy_cnt;
    int done_seen;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b0, ALU_ADD, '0, '0, '0);
    #2;
    chk_out("rst", 1'b0, 32'h0, 1'b1, 1'b0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk_out("idle", 1'b0, 32'h0, 1'b1, 1'b0);

    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
    chk_out("add_ovf", 1'b1, 32'h8000_0000, 1'b0, 1'b0);
    tick();
    chk_out("add_hold", 1'b0, 32'h8000_0000, 1'b0, 1'b0);

    issue(ALU_SUB, 32'd5, 32'd5, 5'd0);
    chk_out("sub_eq", 1'b1, 32'h0, 1'b1, 1'b0);

    issue(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0);
    chk_out("slt_neg", 1'b1, 32'h1, 1'b0, 1'b0);
    issue(ALU_SLT, 32'h1, 32'hFFFF_FFFF, 5'd0);
    chk_out("slt_swp", 1'b1, 32'h0, 1'b1, 1'b0);

    issue(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
    chk_out("and", 1'b1, 32'h00F0_1200, 1'b0, 1'b0);
    issue(ALU_OR, 32'hF000_0001, 32'h0000_0F00, 5'd0);
    chk_out("or", 1'b1, 32'hF000_0F01, 1'b0, 1'b0);
    issue(ALU_JR, 32'h0040_0020, 32'h1234_5678, 5'd3);
    chk_out("jr", 1'b1, 32'h0040_0020, 1'b0, 1'b0);

    // back-to-back single-cycle ops: done high twice
    @(negedge clk);
    drive(1'b1, ALU_ADD, 32'd1, 32'd1, 5'd0);
    tick();
    chk_out("b2b_1", 1'b1, 32'd2, 1'b0, 1'b0);
    drive(1'b1, ALU_SUB, 32'd9, 32'd4, 5'd0);
    tick();
    bus.start = 1'b0;
    chk_out("b2b_2", 1'b1, 32'd5, 1'b0, 1'b0);

    // sll 3<<4 with an ignored start while busy
    issue(ALU_SLL, 32'h0, 32'h3, 5'd4);
    busy_cnt  = 0;
    done_seen = 0;
    n         = 0;
    check("sll4_busy0", 32'(bus.busy), 32'h1);
    check("sll4_done0", 32'(bus.done), 32'h0);
    @(negedge clk);
    drive(1'b1, ALU_ADD, 32'd100, 32'd1, 5'd0);
    while (bus.busy === 1'b1 && busy_cnt < 20) begin
      busy_cnt++;
      tick();
      n++;
      bus.start = 1'b0;
      if (bus.done === 1'b1) done_seen++;
    end
    check("sll4_busy_cyc", 32'(busy_cnt), 32'd4);
    check("sll4_done_cnt", 32'(done_seen), 32'd1);
    chk_out("sll4", 1'b1, 32'h30, 1'b0, 1'b0);
    tick();
    chk_out("sll4_ign", 1'b0, 32'h30, 1'b0, 1'b0);
    check("sll4_idle", 32'(bus.busy), 32'h0);

    issue(ALU_SLL, 32'h0, 32'h0000_ABCD, 5'd0);
    chk_out("sll0", 1'b1, 32'h0000_ABCD, 1'b0, 1'b0);
    check("sll0_busy", 32'(bus.busy), 32'h0);

    issue(ALU_SLL, 32'h0, 32'h1, 5'd31);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("sll31_lat", 32'(n), 32'd31);
    chk_out("sll31", 1'b1, 32'h8000_0000, 1'b0, 1'b0);

    issue(4'b0101, 32'h5, 32'h6, 5'd0);
    chk_out("illeg", 1'b1, 32'h0, 1'b1, 1'b1);
    issue(ALU_ADD, 32'd7, 32'd8, 5'd0);
    chk_out("ill_clr", 1'b1, 32'd15, 1'b0, 1'b0);

    // abort an sll mid-flight with async reset
    issue(ALU_SLL, 32'h0, 32'h1, 5'd10);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk_out("abort", 1'b0, 32'h0, 1'b1, 1'b0);
    check("abort_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.done === 1'b1) done_seen++;
    end
    check("abort_nodone", 32'(done_seen), 32'h0);
    issue(ALU_ADD, 32'd2, 32'd3, 5'd0);
    chk_out("post_rst", 1'b1, 32'd5, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
